// File: rtl/pixel_stream_sink.sv
// pixel_stream_sink
//   Receiving end of the renderer pixel stream. Clips pixels to the visible
//   screen, converts (x,y) to a linear framebuffer address, buffers accepted
//   pixels in a small FIFO and drains them to the framebuffer write port over
//   a ready/valid handshake. Reports idle, a sticky overflow flag and a
//   saturating clipped-pixel count.
//
//   Optional build macro: PIXEL_SINK_COLOR_KEY_EN
//     defined   -> in-range pixels whose colour equals KEY_COLOR are discarded
//                  at ingress (no store, no clip count, no overflow).
//     undefined -> KEY_COLOR is ignored; every in-range pixel is written.
//
// Ports
//   clk          in   system clock
//   resetn       in   asynchronous active-low reset
//   x_stream     in   pixel x (9 bits)
//   y_stream     in   pixel y (8 bits)
//   color_stream in   pixel colour (3 bits)
//   writeEn      in   pixel valid, one pixel per high cycle
//   in_ready     out  sink can accept an in-range pixel this cycle
//   mem_addr     out  framebuffer address of the FIFO head (y*SCREEN_W + x)
//   mem_color    out  framebuffer write data of the FIFO head
//   mem_we       out  write valid (FIFO non-empty)
//   mem_ready    in   framebuffer accepts the write this cycle
//   idle         out  stage register and FIFO both empty
//   overflow     out  sticky: pixel dropped for lack of space
//   clip_count   out  saturating count of clipped pixels
//   clear_flags  in   synchronous clear of overflow and clip_count
module pixel_stream_sink #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned SCREEN_W  = 320,
   parameter int unsigned SCREEN_H  = 240,
   parameter logic [2:0]  KEY_COLOR = 3'b000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [8:0]  x_stream,
   input  logic [7:0]  y_stream,
   input  logic [2:0]  color_stream,
   input  logic        writeEn,
   output logic        in_ready,
   output logic [16:0] mem_addr,
   output logic [2:0]  mem_color,
   output logic        mem_we,
   input  logic        mem_ready,
   output logic        idle,
   output logic        overflow,
   output logic [15:0] clip_count,
   input  logic        clear_flags
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [9:0]  SCREEN_W_L = 10'(SCREEN_W);
   localparam logic [8:0]  SCREEN_H_L = 9'(SCREEN_H);

`ifdef PIXEL_SINK_COLOR_KEY_EN
   localparam bit KEY_EN = 1'b1;
`else
   localparam bit KEY_EN = 1'b0;
`endif

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // control state
   logic          stage_valid_q, stage_valid_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic [15:0]   clip_cnt_q, clip_cnt_d;

   // datapath storage (not reset: validity is carried by the control state)
   logic [16:0]   stage_addr_q;
   logic [2:0]    stage_color_q;
   logic [16:0]   fifo_addr_q  [DEPTH];
   logic [2:0]    fifo_color_q [DEPTH];

   logic          clip_hit, key_hit, in_range_px, accept, drop, push, pop;
   logic [CW:0]   occupancy;
   logic [16:0]   y_ext, pix_addr;

   // ---- ingress: clip, key, space check, address conversion ----
   assign clip_hit    = writeEn &&
                        (({1'b0, x_stream} >= SCREEN_W_L) || ({1'b0, y_stream} >= SCREEN_H_L));
   assign key_hit     = KEY_EN && (color_stream == KEY_COLOR);
   assign in_range_px = writeEn && !clip_hit && !key_hit;

   // A pop in this cycle is deliberately not credited, keeping in_ready
   // independent of mem_ready.
   assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, stage_valid_q};
   assign in_ready  = occupancy < (CW + 1)'(DEPTH);

   assign accept = in_range_px && in_ready;
   assign drop   = in_range_px && !in_ready;

   // y*320 + x as shift-add; the maximum (76799) fits 17 bits.
   assign y_ext    = {9'd0, y_stream};
   assign pix_addr = (y_ext << 8) + (y_ext << 6) + {8'd0, x_stream};

   // ---- stage -> FIFO push, FIFO head -> framebuffer pop ----
   assign push = stage_valid_q;
   assign pop  = mem_we && mem_ready;

   always_comb begin
      stage_valid_d = accept;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      overflow_d    = overflow_q;
      clip_cnt_d    = clip_cnt_q;

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // Clear wins over any event in the same cycle.
      if (clear_flags) begin
         overflow_d = 1'b0;
         clip_cnt_d = 16'd0;
      end else begin
         if (drop)     overflow_d = 1'b1;
         if (clip_hit) clip_cnt_d = sat_inc16(clip_cnt_q);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stage_valid_q <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         overflow_q    <= 1'b0;
         clip_cnt_q    <= 16'd0;
      end else begin
         stage_valid_q <= stage_valid_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         overflow_q    <= overflow_d;
         clip_cnt_q    <= clip_cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         stage_addr_q  <= pix_addr;
         stage_color_q <= color_stream;
      end
      if (push) begin
         fifo_addr_q[wr_ptr_q]  <= stage_addr_q;
         fifo_color_q[wr_ptr_q] <= stage_color_q;
      end
   end

   // ---- egress outputs ----
   // Head is gated with mem_we so the port reads zero whenever nothing is queued.
   assign mem_we     = (count_q != '0);
   assign mem_addr   = mem_we ? fifo_addr_q[rd_ptr_q]  : 17'd0;
   assign mem_color  = mem_we ? fifo_color_q[rd_ptr_q] : 3'd0;
   assign idle       = !stage_valid_q && (count_q == '0);
   assign overflow   = overflow_q;
   assign clip_count = clip_cnt_q;

endmodule

// File: tb/tb_pixel_stream_sink.sv
module tb_pixel_stream_sink;

   logic        clk;
   logic        resetn;
   logic [8:0]  x_stream;
   logic [7:0]  y_stream;
   logic [2:0]  color_stream;
   logic        writeEn;
   logic        in_ready;
   logic [16:0] mem_addr;
   logic [2:0]  mem_color;
   logic        mem_we;
   logic        mem_ready;
   logic        idle;
   logic        overflow;
   logic [15:0] clip_count;
   logic        clear_flags;

   pixel_stream_sink dut (
      .clk(clk), .resetn(resetn),
      .x_stream(x_stream), .y_stream(y_stream), .color_stream(color_stream),
      .writeEn(writeEn), .in_ready(in_ready),
      .mem_addr(mem_addr), .mem_color(mem_color), .mem_we(mem_we),
      .mem_ready(mem_ready), .idle(idle), .overflow(overflow),
      .clip_count(clip_count), .clear_flags(clear_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [16:0] addr;
      logic [2:0]  color;
   } wr_t;

   typedef struct {
      logic [8:0] x;
      logic [7:0] y;
      logic [2:0] c;
      bit         exp_wr;
      int         exp_clip;
   } vec_t;

   wr_t exp_q[$];
   int  n_pass = 0;
   int  n_total = 0;
   int  write_cnt = 0;
   int  cyc = 0;
   int  first_wr_cyc = -1;
   int  last_wr_cyc = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d required %0d", name, act, exp);
   endtask

   always @(posedge clk) cyc++;

   // Scoreboard: a write handshake seen at the negedge completes on the next posedge.
   always @(negedge clk) begin
      if (resetn && mem_we && mem_ready) begin
         write_cnt++;
         if (first_wr_cyc < 0) first_wr_cyc = cyc;
         last_wr_cyc = cyc;
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: got addr %0d required no write", mem_addr);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(e.addr));
            chk("wr_color", 32'(mem_color), 32'(e.color));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [8:0] x, input logic [7:0] y, input logic [2:0] c);
      writeEn = 1'b1;
      x_stream = x;
      y_stream = y;
      color_stream = c;
   endtask

   task automatic push_exp(input logic [8:0] x, input logic [7:0] y, input logic [2:0] c);
      wr_t e;
      e.addr  = 17'(int'(y) * 320 + int'(x));
      e.color = c;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      writeEn = 1'b0;
      clear_flags = 1'b0;
      resetn = 1'b0;
      tick();
      tick();
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_color", 32'(mem_color), 0);
      chk("rst_idle", 32'(idle), 1);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_clip", 32'(clip_count), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      exp_q.delete();
      resetn = 1'b1;
      tick();
   endtask

   task automatic wait_drain(input string name, input int max_cyc);
      for (int i = 0; i < max_cyc && (exp_q.size() != 0 || !idle); i++) tick();
      chk({name, "_drain_left"}, 32'(exp_q.size()), 0);
      chk({name, "_idle"}, 32'(idle), 1);
   endtask

   initial begin
      vec_t vecs[6];
      int   wr0;
      int   low_cnt;

      vecs[0] = '{x: 9'd320, y: 8'd0,   c: 3'd1, exp_wr: 1'b0, exp_clip: 1};
      vecs[1] = '{x: 9'd0,   y: 8'd240, c: 3'd2, exp_wr: 1'b0, exp_clip: 2};
      vecs[2] = '{x: 9'd319, y: 8'd239, c: 3'd3, exp_wr: 1'b1, exp_clip: 2};
      vecs[3] = '{x: 9'd0,   y: 8'd0,   c: 3'd7, exp_wr: 1'b1, exp_clip: 2};
      vecs[4] = '{x: 9'd511, y: 8'd255, c: 3'd4, exp_wr: 1'b0, exp_clip: 3};
      vecs[5] = '{x: 9'd100, y: 8'd100, c: 3'd6, exp_wr: 1'b1, exp_clip: 3};

      x_stream = '0; y_stream = '0; color_stream = '0;
      writeEn = 1'b0; mem_ready = 1'b1; clear_flags = 1'b0; resetn = 1'b0;

      // Test 1: single pixel latency and idle timing
      do_reset();
      mem_ready = 1'b1;
      tick();
      drive(9'd5, 8'd2, 3'b101);
      push_exp(9'd5, 8'd2, 3'b101);
      @(negedge clk);
      chk("t1_we_N", 32'(mem_we), 0);
      tick();
      writeEn = 1'b0;
      @(negedge clk);
      chk("t1_we_N1", 32'(mem_we), 0);
      chk("t1_idle_N1", 32'(idle), 0);
      tick();
      @(negedge clk);
      chk("t1_we_N2", 32'(mem_we), 1);
      chk("t1_addr_N2", 32'(mem_addr), 645);
      chk("t1_color_N2", 32'(mem_color), 5);
      chk("t1_idle_N2", 32'(idle), 0);
      tick();
      @(negedge clk);
      chk("t1_we_N3", 32'(mem_we), 0);
      chk("t1_idle_N3", 32'(idle), 1);

      // Test 2: table of clipped / in-range pixels
      do_reset();
      mem_ready = 1'b1;
      wr0 = write_cnt;
      for (int i = 0; i < 6; i++) begin
         tick();
         drive(vecs[i].x, vecs[i].y, vecs[i].c);
         if (vecs[i].exp_wr) push_exp(vecs[i].x, vecs[i].y, vecs[i].c);
         @(negedge clk);
         chk($sformatf("t2_in_ready_%0d", i), 32'(in_ready), 1);
         tick();
         writeEn = 1'b0;
         @(negedge clk);
         chk($sformatf("t2_clip_%0d", i), 32'(clip_count), 32'(vecs[i].exp_clip));
      end
      tick();
      wait_drain("t2", 20);
      chk("t2_writes", 32'(write_cnt - wr0), 3);
      chk("t2_overflow", 32'(overflow), 0);

      // Test 3: back-pressure fills the FIFO, two pixels dropped
      do_reset();
      mem_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         drive(9'(i), 8'd0, 3'd2);
         if (i < 8) push_exp(9'(i), 8'd0, 3'd2);
         @(negedge clk);
         chk($sformatf("t3_in_ready_%0d", i), 32'(in_ready), (i < 8) ? 1 : 0);
      end
      tick();
      writeEn = 1'b0;
      @(negedge clk);
      chk("t3_overflow", 32'(overflow), 1);
      chk("t3_in_ready_full", 32'(in_ready), 0);
      chk("t3_head_we", 32'(mem_we), 1);
      chk("t3_head_addr", 32'(mem_addr), 0);
      repeat (3) tick();
      @(negedge clk);
      chk("t3_head_stable", 32'(mem_addr), 0);
      wr0 = write_cnt;
      tick();
      mem_ready = 1'b1;
      wait_drain("t3", 30);
      chk("t3_writes", 32'(write_cnt - wr0), 8);

      // Test 4: 100 back-to-back pixels, full throughput
      do_reset();
      mem_ready = 1'b1;
      wr0 = write_cnt;
      first_wr_cyc = -1;
      low_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         logic [8:0] x;
         logic [7:0] y;
         logic [2:0] c;
         tick();
         x = 9'((i * 7) % 320);
         y = 8'((i * 3) % 240);
         c = 3'($urandom_range(1, 7));
         drive(x, y, c);
         push_exp(x, y, c);
         @(negedge clk);
         if (!in_ready) low_cnt++;
      end
      tick();
      writeEn = 1'b0;
      wait_drain("t4", 20);
      chk("t4_writes", 32'(write_cnt - wr0), 100);
      chk("t4_consecutive", 32'(last_wr_cyc - first_wr_cyc), 99);
      chk("t4_in_ready_low", 32'(low_cnt), 0);
      chk("t4_overflow", 32'(overflow), 0);

      // Test 5: asynchronous reset discards queued pixels
      do_reset();
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         drive(9'(20 + i), 8'd3, 3'd5);
      end
      tick();
      writeEn = 1'b0;
      tick();
      @(negedge clk);
      chk("t5_we_before", 32'(mem_we), 1);
      tick();
      #2;
      resetn = 1'b0;
      #1;
      chk("t5_we_async", 32'(mem_we), 0);
      chk("t5_idle_async", 32'(idle), 1);
      tick();
      resetn = 1'b1;
      mem_ready = 1'b1;
      wr0 = write_cnt;
      repeat (10) tick();
      chk("t5_writes", 32'(write_cnt - wr0), 0);

      // Test 6: clip saturation and clear priority
      do_reset();
      mem_ready = 1'b1;
      tick();
      drive(9'd400, 8'd0, 3'd1);
      repeat (65535) @(posedge clk);
      #1;
      writeEn = 1'b0;
      @(negedge clk);
      chk("t6_clip_max", 32'(clip_count), 65535);
      tick();
      drive(9'd400, 8'd0, 3'd1);
      tick();
      writeEn = 1'b0;
      @(negedge clk);
      chk("t6_clip_sat", 32'(clip_count), 65535);
      chk("t6_no_ovf", 32'(overflow), 0);
      mem_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick();
         drive(9'(i), 8'd1, 3'd3);
         if (i < 8) push_exp(9'(i), 8'd1, 3'd3);
      end
      tick();
      writeEn = 1'b0;
      @(negedge clk);
      chk("t6_ovf_set", 32'(overflow), 1);
      tick();
      drive(9'd400, 8'd0, 3'd1);
      clear_flags = 1'b1;
      tick();
      writeEn = 1'b0;
      clear_flags = 1'b0;
      @(negedge clk);
      chk("t6_clear_clip", 32'(clip_count), 0);
      chk("t6_clear_ovf", 32'(overflow), 0);
      tick();
      drive(9'd50, 8'd1, 3'd3);
      clear_flags = 1'b1;
      tick();
      writeEn = 1'b0;
      clear_flags = 1'b0;
      @(negedge clk);
      chk("t6_clear_vs_drop", 32'(overflow), 0);
      tick();
      mem_ready = 1'b1;
      wr0 = write_cnt;
      wait_drain("t6", 30);
      chk("t6_writes", 32'(write_cnt - wr0), 8);

      // Colour key behaviour
      wr0 = write_cnt;
      tick();
      drive(9'd10, 8'd10, 3'b000);
`ifndef PIXEL_SINK_COLOR_KEY_EN
      push_exp(9'd10, 8'd10, 3'b000);
`endif
      tick();
      writeEn = 1'b0;
      repeat (4) tick();
      @(negedge clk);
`ifdef PIXEL_SINK_COLOR_KEY_EN
      chk("key_writes", 32'(write_cnt - wr0), 0);
`else
      chk("key_writes", 32'(write_cnt - wr0), 1);
`endif
      chk("key_clip", 32'(clip_count), 0);
      chk("key_ovf", 32'(overflow), 0);
      chk("key_idle", 32'(idle), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pixel_stream_sink.md
Name: pixel_stream_sink

Overview:
- Receiving end of the renderer pixel stream (x_stream/y_stream/color_stream/writeEn), as produced by the rect and other render blocks.
- Clips pixels to the 320x240 screen and converts (x,y) to a linear framebuffer address.
- Buffers pixels in a small FIFO and drains them to the framebuffer write port through a ready/valid handshake.
- Reports flush status (idle), overflow and clipped-pixel statistics to the draw sequencer.

Parameters:
DEPTH, 8, FIFO entries; power of two, >=2
SCREEN_W, 320, visible width; x >= SCREEN_W is clipped
SCREEN_H, 240, visible height; y >= SCREEN_H is clipped
KEY_COLOR, 3'b000, transparent colour; used only with the optional feature

Ports:
clk  in  1  system clock (50 MHz)
resetn  in  1  asynchronous active-low reset
x_stream  in  9  pixel x
y_stream  in  8  pixel y
color_stream  in  3  pixel colour
writeEn  in  1  pixel valid, one pixel per high cycle
in_ready  out  1  sink can accept a pixel this cycle
mem_addr  out  17  framebuffer address = y*SCREEN_W + x
mem_color  out  3  framebuffer write data
mem_we  out  1  write valid (FIFO non-empty)
mem_ready  in  1  framebuffer accepts write this cycle
idle  out  1  stage register and FIFO both empty
overflow  out  1  sticky: pixel dropped for lack of space
clip_count  out  16  saturating count of clipped pixels
clear_flags  in  1  synchronous clear of overflow and clip_count

Behaviour:
- Reset (resetn low, asynchronous):
  - FIFO pointers and count = 0; stage_valid = 0.
  - mem_we = 0, mem_addr = 0, mem_color = 0; idle = 1; overflow = 0; clip_count = 0.
  - In-flight pixels are discarded and are never written after reset releases.
- in_ready = (fifo_count + stage_valid) < DEPTH, combinational. A pop in the same cycle is not credited.
- Ingress, in the cycle writeEn = 1:
  - Clipped when x >= SCREEN_W or y >= SCREEN_H: pixel is not stored; clip_count += 1, saturating at 16'hFFFF.
  - Otherwise, if in_ready = 0: pixel is dropped and overflow is set to 1 (sticky).
  - Otherwise: stage register captures addr = (y<<8)+(y<<6)+x (17-bit, no truncation) and colour; stage_valid = 1.
  - Clip takes priority over overflow; a clipped pixel never sets overflow.
- Stage: a valid stage entry is always pushed into the FIFO on the next edge. The in_ready rule guarantees space.
- Egress:
  - mem_we = FIFO non-empty; mem_addr and mem_color show the FIFO head.
  - Pop on an edge where mem_we && mem_ready.
  - Head outputs must stay stable while mem_we = 1 and mem_ready = 0.
- Push and pop in the same cycle: both happen and the count is unchanged.
- Latency: pixel accepted in cycle N -> mem_we high in cycle N+2 at the earliest. Sustained throughput is 1 pixel/cycle with mem_ready held high.
- Ordering: writes leave in acceptance order; pointers wrap modulo DEPTH.
- idle = !stage_valid && fifo_count == 0.
- clear_flags = 1: overflow and clip_count go to 0 on that edge. Clear wins over a simultaneous clip or overflow event, which is not recorded.
- writeEn low: no state change on the ingress side.

Optional Feature:
PIXEL_SINK_COLOR_KEY_EN
- Defined: an in-range pixel with color_stream == KEY_COLOR is discarded at ingress. It is not stored, not counted in clip_count, does not set overflow, and does not consume space.
- Undefined: KEY_COLOR is ignored and all in-range pixels are written.

Test Plan:
1. Single pixel x=5, y=2, colour 3'b101 in cycle N, mem_ready=1 -> mem_we high only in N+2 with mem_addr=645, mem_color=101; idle low in N+1..N+2 and high from N+3.
2. Pixels (320,0), (0,240), then (319,239) -> clip_count=2, exactly one write at addr 76799, overflow=0.
3. mem_ready=0, 10 consecutive pixels at x=0..9, y=0, DEPTH=8 -> in_ready low after the 8th accepted pixel; pixels 8 and 9 dropped; overflow=1. Then mem_ready=1 -> exactly 8 writes at addr 0..7 in order.
4. 100 consecutive in-range pixels with mem_ready=1 -> 100 writes on consecutive cycles, in_ready never low, overflow=0.
5. Four pixels queued with mem_ready=0, then resetn pulsed low mid-cycle -> mem_we drops immediately, idle=1; after release, mem_ready=1 produces no writes.
6. clip_count preloaded to 65535 via clipped pixels, one more clip -> stays 65535. clear_flags together with a clipped pixel -> clip_count=0, overflow=0. With PIXEL_SINK_COLOR_KEY_EN defined, a pixel of colour 3'b000 -> no write and no flag change.
